// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - raster timing constants and pixel scale encoding
package vga_timing_pkg;

    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;
    localparam int VGA_CW       = 11;

    localparam logic [1:0] SCALE_1X = 2'd0;
    localparam logic [1:0] SCALE_2X = 2'd1;
    localparam logic [1:0] SCALE_4X = 2'd2;

    // Code 3 is reserved and saturates to the coarsest scale.
    function automatic logic [1:0] scale_shift(input logic [1:0] s);
        return (s > SCALE_4X) ? SCALE_4X : s;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// rtl/vga_axis_counter.sv - one raster axis: counter, wrap flag, next-state window decode
module vga_axis_counter #(
    parameter int CW         = 11,
    parameter int TOTAL      = 800,
    parameter int ACTIVE     = 640,
    parameter int SYNC_START = 656,
    parameter int SYNC_END   = 752
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          inc,
    output logic [CW-1:0] cnt_nxt,
    output logic          wrap,
    output logic          active_nxt,
    output logic          sync_nxt
);

    localparam logic [CW-1:0] LAST   = CW'(TOTAL - 1);
    localparam logic [CW-1:0] ACT    = CW'(ACTIVE);
    localparam logic [CW-1:0] SY_BEG = CW'(SYNC_START);
    localparam logic [CW-1:0] SY_END = CW'(SYNC_END);

    logic [CW-1:0] cnt;

    assign wrap = (cnt == LAST);

    always_comb begin
        cnt_nxt = cnt;
        if (clr)
            cnt_nxt = '0;
        else if (inc)
            cnt_nxt = wrap ? '0 : cnt + CW'(1);
    end

    // Windows are decoded from the next count so registered outputs line up with the counter.
    assign active_nxt = (cnt_nxt < ACT);
    assign sync_nxt   = (cnt_nxt >= SY_BEG) && (cnt_nxt < SY_END);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else
            cnt <= cnt_nxt;
    end

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - parametrised raster timing generator with scaled coordinates
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int   H_ACTIVE = VGA_H_ACTIVE,
    parameter int   H_FP     = VGA_H_FP,
    parameter int   H_SYNC   = VGA_H_SYNC,
    parameter int   H_BP     = VGA_H_BP,
    parameter int   V_ACTIVE = VGA_V_ACTIVE,
    parameter int   V_FP     = VGA_V_FP,
    parameter int   V_SYNC   = VGA_V_SYNC,
    parameter int   V_BP     = VGA_V_BP,
    parameter logic HS_POL   = 1'b0,
    parameter logic VS_POL   = 1'b0,
    parameter int   CW       = VGA_CW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pix_ce,
    input  logic          en,
    input  logic [1:0]    scale_x,
    input  logic [1:0]    scale_y,
    input  logic          irq_ack,
    output logic          h_sync,
    output logic          v_sync,
    output logic          de,
    output logic [CW-1:0] posx,
    output logic [CW-1:0] posy,
    output logic          line_start,
    output logic          frame_start,
    output logic          vblank_irq,
    output logic [7:0]    frame_cnt
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    logic          running;
    logic          step, frame_wrap, load_scale, irq_set;
    logic          h_wrap, v_wrap, h_act, v_act, h_sy, v_sy;
    logic [CW-1:0] h_nxt, v_nxt;
    logic [1:0]    sx_act, sy_act, sx_nxt, sy_nxt;

    vga_axis_counter #(
        .CW(CW), .TOTAL(H_TOTAL), .ACTIVE(H_ACTIVE),
        .SYNC_START(H_ACTIVE + H_FP), .SYNC_END(H_ACTIVE + H_FP + H_SYNC)
    ) u_h_axis (
        .clk(clk), .rst(rst), .clr(~en), .inc(step),
        .cnt_nxt(h_nxt), .wrap(h_wrap), .active_nxt(h_act), .sync_nxt(h_sy)
    );

    vga_axis_counter #(
        .CW(CW), .TOTAL(V_TOTAL), .ACTIVE(V_ACTIVE),
        .SYNC_START(V_ACTIVE + V_FP), .SYNC_END(V_ACTIVE + V_FP + V_SYNC)
    ) u_v_axis (
        .clk(clk), .rst(rst), .clr(~en), .inc(step & h_wrap),
        .cnt_nxt(v_nxt), .wrap(v_wrap), .active_nxt(v_act), .sync_nxt(v_sy)
    );

    // The first pix_ce cycle after enable presents (0,0) rather than advancing.
    assign step       = en & pix_ce & running;
    assign frame_wrap = step & h_wrap & v_wrap;
    assign load_scale = en & pix_ce & (~running | (h_wrap & v_wrap));
    assign sx_nxt     = load_scale ? scale_shift(scale_x) : sx_act;
    assign sy_nxt     = load_scale ? scale_shift(scale_y) : sy_act;
    assign irq_set    = step & (h_nxt == '0) & (v_nxt == CW'(V_ACTIVE));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            running     <= 1'b0;
            sx_act      <= SCALE_1X;
            sy_act      <= SCALE_1X;
            h_sync      <= ~HS_POL;
            v_sync      <= ~VS_POL;
            de          <= 1'b0;
            posx        <= '0;
            posy        <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            vblank_irq  <= 1'b0;
            frame_cnt   <= 8'd0;
        end else begin
            if (frame_wrap)
                frame_cnt <= frame_cnt + 8'd1;
            if (irq_set)
                vblank_irq <= 1'b1;
            else if (irq_ack)
                vblank_irq <= 1'b0;

            if (!en) begin
                running     <= 1'b0;
                sx_act      <= SCALE_1X;
                sy_act      <= SCALE_1X;
                h_sync      <= ~HS_POL;
                v_sync      <= ~VS_POL;
                de          <= 1'b0;
                posx        <= '0;
                posy        <= '0;
                line_start  <= 1'b0;
                frame_start <= 1'b0;
            end else if (pix_ce) begin
                running     <= 1'b1;
                sx_act      <= sx_nxt;
                sy_act      <= sy_nxt;
                h_sync      <= h_sy ? HS_POL : ~HS_POL;
                v_sync      <= v_sy ? VS_POL : ~VS_POL;
                de          <= h_act & v_act;
                posx        <= h_nxt >> sx_nxt;
                posy        <= v_nxt >> sy_nxt;
                line_start  <= (h_nxt == '0);
                frame_start <= (h_nxt == '0) && (v_nxt == '0);
            end else begin
                line_start  <= 1'b0;
                frame_start <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - self-checking bench for vga_timing_gen
module tb_vga_timing_gen;

    localparam int HA = 8, HF = 2, HS = 3, HB = 1;
    localparam int VA = 4, VF = 1, VS = 2, VB = 1;
    localparam int CW = 6;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FT = HT * VT;

    typedef struct packed {
        logic          hs, vs, de;
        logic [CW-1:0] px, py;
        logic          ls, fs, irq;
        logic [7:0]    fc;
    } out_t;

    typedef struct {
        logic       rst, en, pce;
        logic [1:0] sx, sy;
        logic       ack;
        out_t       exp;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1, en = 1'b0, pix_ce = 1'b0, irq_ack = 1'b0;
    logic [1:0]    scale_x = 2'd0, scale_y = 2'd0;
    logic          h_sync, v_sync, de, line_start, frame_start, vblank_irq;
    logic [CW-1:0] posx, posy;
    logic [7:0]    frame_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .HS_POL(1'b0), .VS_POL(1'b0), .CW(CW)
    ) dut (
        .clk(clk), .rst(rst), .pix_ce(pix_ce), .en(en),
        .scale_x(scale_x), .scale_y(scale_y), .irq_ack(irq_ack),
        .h_sync(h_sync), .v_sync(v_sync), .de(de), .posx(posx), .posy(posy),
        .line_start(line_start), .frame_start(frame_start),
        .vblank_irq(vblank_irq), .frame_cnt(frame_cnt)
    );

    // Reference model: a linear pixel index since the frame sequence started.
    bit         m_started;
    int         m_p, m_sx, m_sy;
    logic [7:0] m_fc;
    logic       m_irq;
    out_t       mo;

    function automatic int eff(input logic [1:0] s);
        return (s == 2'd3) ? 2 : int'(s);
    endfunction

    function automatic out_t mk(input logic hs, vs, d, input int px, py, input logic ls, fs);
        out_t o;
        o.hs = hs; o.vs = vs; o.de = d; o.px = CW'(px); o.py = CW'(py);
        o.ls = ls; o.fs = fs; o.irq = 1'b0; o.fc = 8'd0;
        return o;
    endfunction

    task automatic model_edge();
        bit set;
        int h, v;
        set = 0;
        if (rst) begin
            m_started = 0; m_p = 0; m_sx = 0; m_sy = 0; m_fc = 8'd0; m_irq = 1'b0;
            mo = mk(1, 1, 0, 0, 0, 0, 0);
        end else begin
            if (!en) begin
                m_started = 0; m_p = 0; m_sx = 0; m_sy = 0;
            end else if (pix_ce) begin
                if (!m_started) begin
                    m_started = 1; m_p = 0; m_sx = eff(scale_x); m_sy = eff(scale_y);
                end else begin
                    m_p++;
                    if (m_p % FT == 0) begin
                        m_fc = m_fc + 8'd1; m_sx = eff(scale_x); m_sy = eff(scale_y);
                    end
                    if (m_p % FT == VA * HT) set = 1;
                end
            end
            if (set) m_irq = 1'b1;
            else if (irq_ack) m_irq = 1'b0;
            if (!en) begin
                mo = mk(1, 1, 0, 0, 0, 0, 0);
            end else if (pix_ce && m_started) begin
                h = m_p % HT;
                v = (m_p / HT) % VT;
                mo = mk(!(h >= HA + HF && h < HA + HF + HS), !(v >= VA + VF && v < VA + VF + VS),
                        (h < HA) && (v < VA), h >> m_sx, v >> m_sy, h == 0, h == 0 && v == 0);
            end else begin
                mo.ls = 1'b0; mo.fs = 1'b0;
            end
            mo.irq = m_irq;
            mo.fc  = m_fc;
        end
    endtask

    function automatic out_t dut_out();
        out_t o;
        o.hs = h_sync; o.vs = v_sync; o.de = de; o.px = posx; o.py = posy;
        o.ls = line_start; o.fs = frame_start; o.irq = vblank_irq; o.fc = frame_cnt;
        return o;
    endfunction

    task automatic check(input string tag, input out_t exp);
        out_t got;
        got = dut_out();
        checks++;
        if (got !== exp) begin
            errors++;
            if (errors <= 20)
                $display("FAIL %s t=%0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    task automatic check_val(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            if (errors <= 20)
                $display("FAIL %s t=%0t: got %0d expected %0d", tag, $time, got, exp);
        end
    endtask

    task automatic cyc(input logic r, e, pc, input logic [1:0] x, y, input logic a, input string tag);
        @(negedge clk);
        rst = r; en = e; pix_ce = pc; scale_x = x; scale_y = y; irq_ack = a;
        model_edge();
        @(posedge clk);
        #1;
        check(tag, mo);
    endtask

    vec_t tv[8];
    int   vs_low, fs_n, rise_n, fs_at[2];
    int   rise_at[2];
    logic prev_irq;
    int   cap[8];

    initial begin
        tv[0] = '{1, 0, 0, 0, 0, 0, mk(1, 1, 0, 0, 0, 0, 0)};
        tv[1] = '{0, 1, 1, 0, 0, 0, mk(1, 1, 1, 0, 0, 1, 1)};
        tv[2] = '{0, 1, 1, 0, 0, 0, mk(1, 1, 1, 1, 0, 0, 0)};
        tv[3] = '{0, 1, 0, 0, 0, 0, mk(1, 1, 1, 1, 0, 0, 0)};
        tv[4] = '{0, 1, 1, 0, 0, 0, mk(1, 1, 1, 2, 0, 0, 0)};
        tv[5] = '{0, 0, 1, 0, 0, 0, mk(1, 1, 0, 0, 0, 0, 0)};
        tv[6] = '{0, 1, 1, 0, 0, 0, mk(1, 1, 1, 0, 0, 1, 1)};
        tv[7] = '{0, 1, 1, 1, 0, 0, mk(1, 1, 1, 1, 0, 0, 0)};

        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            rst = tv[i].rst; en = tv[i].en; pix_ce = tv[i].pce;
            scale_x = tv[i].sx; scale_y = tv[i].sy; irq_ack = tv[i].ack;
            model_edge();
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", i), tv[i].exp);
        end

        // Two full frames plus the wrap into the third.
        cyc(1, 0, 0, 0, 0, 0, "rst_a");
        vs_low = 0; fs_n = 0; rise_n = 0; prev_irq = 1'b0;
        rise_at[0] = -1; rise_at[1] = -1;
        for (int i = 0; i <= 2 * FT; i++) begin
            cyc(0, 1, 1, 0, 0, i == 60, "frames");
            if (i < FT && !v_sync) vs_low++;
            if (frame_start) fs_n++;
            if (vblank_irq && !prev_irq) begin
                if (rise_n < 2) rise_at[rise_n] = i;
                rise_n++;
            end
            prev_irq = vblank_irq;
        end
        check_val("vsync_low_clks", vs_low, 28);
        check_val("frame_start_cnt", fs_n, 3);
        check_val("frame_cnt_2", int'(frame_cnt), 2);
        check_val("irq_rise_cnt", rise_n, 2);
        check_val("irq_rise0", rise_at[0], 56);
        check_val("irq_rise1", rise_at[1], FT + 56);

        // Scale changes mid-frame take effect only after the wrap.
        for (int i = 1; i < FT; i++) begin
            cyc(0, 1, 1, (i < 20) ? 2'd0 : 2'd1, 0, 0, "scale_mid");
            if (i == 27) check_val("posx_unscaled_mid", int'(posx), 13);
        end
        for (int i = 0; i < 8; i++) begin
            cyc(0, 1, 1, 1, 0, 0, "scale2x");
            cap[i] = int'(posx);
        end
        for (int i = 0; i < 8; i++) check_val($sformatf("posx2x_%0d", i), cap[i], i / 2);
        for (int i = 0; i < FT - 8; i++) cyc(0, 1, 1, 3, 0, 0, "scale_wait");
        for (int i = 0; i < 8; i++) begin
            cyc(0, 1, 1, 3, 0, 0, "scale4x");
            cap[i] = int'(posx);
        end
        for (int i = 0; i < 8; i++) check_val($sformatf("posx4x_%0d", i), cap[i], i / 4);

        // Set and acknowledge on the same edge: set wins.
        cyc(0, 1, 1, 0, 0, 1, "ack_clear");
        for (int i = 0; i < FT && (m_p % FT) != VA * HT - 1; i++) cyc(0, 1, 1, 0, 0, 0, "to_vblank");
        cyc(0, 1, 1, 0, 0, 1, "ack_collide");
        check_val("irq_set_wins", int'(vblank_irq), 1);
        cyc(0, 1, 1, 0, 0, 1, "ack_next");
        check_val("irq_acked", int'(vblank_irq), 0);
        cyc(0, 1, 1, 0, 0, 1, "ack_idle");
        check_val("irq_ack_idle", int'(vblank_irq), 0);

        // Half-rate pixel enable doubles the frame period.
        cyc(1, 0, 0, 0, 0, 0, "rst_d");
        fs_n = 0; fs_at[0] = -1; fs_at[1] = -1;
        for (int i = 0; i < 2 * 2 * FT + 2; i++) begin
            cyc(0, 1, (i % 2) == 0, 0, 0, 0, "half_rate");
            if (frame_start) begin
                if (fs_n < 2) fs_at[fs_n] = i;
                fs_n++;
            end
        end
        check_val("half_rate_period", fs_at[1] - fs_at[0], 2 * FT);
        check_val("half_rate_fs_cnt", fs_n, 3);

        // Reset mid-frame at h=5, v=2, then enable cycling.
        cyc(1, 0, 0, 0, 0, 0, "rst_e");
        for (int i = 0; i < 2 * HT + 6; i++) cyc(0, 1, 1, 0, 0, 0, "pre_abort");
        check_val("abort_posx", int'(posx), 5);
        check_val("abort_posy", int'(posy), 2);
        cyc(1, 1, 1, 0, 0, 0, "abort_rst");
        cyc(0, 0, 1, 0, 0, 0, "en_low0");
        cyc(0, 0, 1, 0, 0, 0, "en_low1");
        cyc(0, 1, 1, 0, 0, 0, "restart");
        check_val("restart_fs", int'(frame_start), 1);
        check_val("restart_ls", int'(line_start), 1);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++)
            cyc(($urandom % 300) == 0, ($urandom % 16) != 0, ($urandom % 4) != 0,
                2'($urandom), 2'($urandom), ($urandom % 8) == 0, "random");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
